alu_operand_stage: RTL and testbench

Pipeline stage directly upstream of the ULA: it captures one decoded instruction, keeps its operands coherent with in-flight writebacks, resolves RAW hazards by bypass or stall, and presents `dataA`/`dataB`/`ALUControl` to the ULA. A valid/ready handshake connects it to decode upstream and to the EX/MEM consumer downstream. It holds at most one instruction.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/operand_bypass.sv | 52 +++++
 rtl/alu_operand_stage.sv | 181 ++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ULA operand path: ULA opcode
//               encodings and the architectural register address width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ULA opcode encodings carried on ALUControl
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    // Architectural register address width (32 registers, x0 hard-wired)
    localparam int REG_ADDR_W = 5;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/operand_bypass.sv
`default_nettype none
// ============================================================================
// Module      : operand_bypass
// Description : Per-operand hazard detection and bypass selection. Compares
//               the held source register against the EX/MEM and WB
//               destinations (x0 never matches) and, when forwarding is
//               built in, selects EX/MEM > WB > held value.
// Config      : ALU_OPERAND_FORWARDING_EN - enables the bypass mux; when
//               undefined the held value is always selected.
// Ports       : rs / use_reg        - held source register, match enable
//               held                - operand value held in the stage
//               exm_* / wb_*        - in-flight destination writes
//               sel_data            - operand presented to the ULA
//               m_exm / m_wb        - match flags for hazard logic
// Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass
    import alu_pkg::*;
#(
    parameter int N  = 64,
    parameter int RA = REG_ADDR_W
) (
    input  logic [RA-1:0] rs,
    input  logic          use_reg,
    input  logic [N-1:0]  held,
    input  logic          exm_reg_write,
    input  logic [RA-1:0] exm_rd,
    input  logic [N-1:0]  exm_data,
    input  logic          wb_reg_write,
    input  logic [RA-1:0] wb_rd,
    input  logic [N-1:0]  wb_data,
    output logic [N-1:0]  sel_data,
    output logic          m_exm,
    output logic          m_wb
);

    // use_reg masks operands that come from an immediate
    assign m_exm = use_reg & exm_reg_write & (exm_rd != '0) & (exm_rd == rs);
    assign m_wb  = use_reg & wb_reg_write  & (wb_rd  != '0) & (wb_rd  == rs);

`ifdef ALU_OPERAND_FORWARDING_EN
    // Youngest producer wins: EX/MEM is newer than WB
    assign sel_data = m_exm ? exm_data : (m_wb ? wb_data : held);
`else
    logic w_unused_fwd;

    assign sel_data     = held;
    assign w_unused_fwd = ^{exm_data, wb_data};
`endif

endmodule : operand_bypass
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Single-entry operand stage in front of the ULA. Captures one
//               decoded instruction, keeps its operands coherent with the
//               writeback port, resolves RAW hazards by bypass or stall and
//               presents dataA/dataB/ALUControl under a valid/ready handshake.
// Config      : ALU_OPERAND_FORWARDING_EN - EX/MEM and WB bypass, only
//               load-use stalls. Undefined: any EX/MEM or WB match stalls.
// Ports       : in_valid/in_ready   - decode handshake
//               rs*/imm/use_imm/... - decoded instruction fields
//               exm_*, wb_*         - in-flight destination writes
//               flush               - kill held and incoming instruction
//               out_valid/out_ready - EX/MEM handshake
//               dataA/dataB/ALUControl/rd_out/reg_write_out - ULA side
//               stall_count         - saturating hazard-stall cycle counter
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int N  = 64,
    parameter int RA = REG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RA-1:0] rs1_addr,
    input  logic [RA-1:0] rs2_addr,
    input  logic [N-1:0]  rs1_data,
    input  logic [N-1:0]  rs2_data,
    input  logic [N-1:0]  imm,
    input  logic          use_imm,
    input  logic [3:0]    alu_ctrl_in,
    input  logic [RA-1:0] rd_in,
    input  logic          reg_write_in,
    input  logic          exm_reg_write,
    input  logic          exm_is_load,
    input  logic [RA-1:0] exm_rd,
    input  logic [N-1:0]  exm_data,
    input  logic          wb_reg_write,
    input  logic [RA-1:0] wb_rd,
    input  logic [N-1:0]  wb_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  dataA,
    output logic [N-1:0]  dataB,
    output logic [3:0]    ALUControl,
    output logic [RA-1:0] rd_out,
    output logic          reg_write_out,
    output logic [31:0]   stall_count
);

    // Held instruction
    logic          r_hv;
    logic [N-1:0]  r_op_a;
    logic [N-1:0]  r_op_b;
    logic [RA-1:0] r_rs1;
    logic [RA-1:0] r_rs2;
    logic          r_b_is_imm;
    logic [3:0]    r_ctrl;
    logic [RA-1:0] r_rd;
    logic          r_reg_write;
    logic [31:0]   r_stall_count;

    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_hazard;
    logic          w_cap_wb_a;
    logic          w_cap_wb_b;
    logic [N-1:0]  w_sel_a;
    logic [N-1:0]  w_sel_b;
    logic          w_a_exm;
    logic          w_a_wb;
    logic          w_b_exm;
    logic          w_b_wb;

    operand_bypass #(.N(N), .RA(RA)) u_bypass_a (
        .rs            (r_rs1),
        .use_reg       (1'b1),
        .held          (r_op_a),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_data      (exm_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .sel_data      (w_sel_a),
        .m_exm         (w_a_exm),
        .m_wb          (w_a_wb)
    );

    operand_bypass #(.N(N), .RA(RA)) u_bypass_b (
        .rs            (r_rs2),
        .use_reg       (~r_b_is_imm),
        .held          (r_op_b),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_data      (exm_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .sel_data      (w_sel_b),
        .m_exm         (w_b_exm),
        .m_wb          (w_b_wb)
    );

`ifdef ALU_OPERAND_FORWARDING_EN
    // Only a load in EX/MEM has no value to forward yet
    assign w_hazard = (w_a_exm | w_b_exm) & exm_is_load;
`else
    logic w_unused_load;

    assign w_hazard      = w_a_exm | w_a_wb | w_b_exm | w_b_wb;
    assign w_unused_load = exm_is_load;
`endif

    assign out_valid  = r_hv & ~w_hazard;
    assign w_out_fire = out_valid & out_ready;
    assign in_ready   = ~r_hv | w_out_fire;
    assign w_in_fire  = in_valid & in_ready;

    // The register file does not see this cycle's writeback yet
    assign w_cap_wb_a = wb_reg_write & (wb_rd != '0) & (wb_rd == rs1_addr);
    assign w_cap_wb_b = wb_reg_write & (wb_rd != '0) & (wb_rd == rs2_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hv        <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_b_is_imm  <= 1'b0;
            r_ctrl      <= 4'b0000;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
        end else if (flush) begin
            r_hv <= 1'b0;
        end else if (w_in_fire) begin
            r_hv        <= 1'b1;
            r_op_a      <= w_cap_wb_a ? wb_data : rs1_data;
            r_op_b      <= use_imm ? imm : (w_cap_wb_b ? wb_data : rs2_data);
            r_rs1       <= rs1_addr;
            r_rs2       <= rs2_addr;
            r_b_is_imm  <= use_imm;
            r_ctrl      <= alu_ctrl_in;
            r_rd        <= rd_in;
            r_reg_write <= reg_write_in;
        end else if (w_out_fire) begin
            r_hv <= 1'b0;
        end else if (r_hv) begin
            // Writeback snoop; w_b_wb is already masked for immediates
            if (w_a_wb) begin
                r_op_a <= wb_data;
            end
            if (w_b_wb) begin
                r_op_b <= wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= 32'd0;
        end else if (r_hv && w_hazard && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign dataA         = w_sel_a;
    assign dataB         = w_sel_b;
    assign ALUControl    = r_ctrl;
    assign rd_out        = r_rd;
    assign reg_write_out = r_reg_write;
    assign stall_count   = r_stall_count;

endmodule : alu_operand_stage
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Directed self-checking bench for alu_operand_stage. Inputs
//               change 1 time unit after the rising edge; outputs are
//               checked 1 time unit after that.
// Config      : ALU_OPERAND_FORWARDING_EN selects the expected stall/bypass
//               behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;
    import alu_pkg::*;

    localparam int N  = 64;
    localparam int RA = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [RA-1:0] rs1_addr, rs2_addr;
    logic [N-1:0]  rs1_data, rs2_data, imm;
    logic          use_imm;
    logic [3:0]    alu_ctrl_in;
    logic [RA-1:0] rd_in;
    logic          reg_write_in;
    logic          exm_reg_write, exm_is_load;
    logic [RA-1:0] exm_rd;
    logic [N-1:0]  exm_data;
    logic          wb_reg_write;
    logic [RA-1:0] wb_rd;
    logic [N-1:0]  wb_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  dataA, dataB;
    logic [3:0]    ALUControl;
    logic [RA-1:0] rd_out;
    logic          reg_write_out;
    logic [31:0]   stall_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_stall = 32'd0;

    alu_operand_stage #(.N(N), .RA(RA)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm(imm), .use_imm(use_imm),
        .alu_ctrl_in(alu_ctrl_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
        .exm_reg_write(exm_reg_write), .exm_is_load(exm_is_load),
        .exm_rd(exm_rd), .exm_data(exm_data), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .dataA(dataA),
        .dataB(dataB), .ALUControl(ALUControl), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        in_valid = 0; rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0;
        imm = '0; use_imm = 0; alu_ctrl_in = 4'b0000; rd_in = '0; reg_write_in = 0;
        exm_reg_write = 0; exm_is_load = 0; exm_rd = '0; exm_data = '0;
        wb_reg_write = 0; wb_rd = '0; wb_data = '0; flush = 0; out_ready = 0;
    endtask

    task automatic drive_instr(input logic [RA-1:0] a1, input logic [N-1:0] d1,
                               input logic [RA-1:0] a2, input logic [N-1:0] d2,
                               input logic ui, input logic [N-1:0] im,
                               input logic [3:0] ctl, input logic [RA-1:0] rd);
        in_valid = 1; rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2;
        use_imm = ui; imm = im; alu_ctrl_in = ctl; rd_in = rd; reg_write_in = 1;
    endtask

    task automatic test_reset;
        set_idle();
        rst_n = 0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (dataA !== 64'h0 || dataB !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", dataA, dataB); end
        n_checks++; if (ALUControl !== 4'b0000 || rd_out !== 5'd0 || reg_write_out !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b/%0d/%b expected 0000/0/0", ALUControl, rd_out, reg_write_out); end
        n_checks++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_count); end
        step(); step();
        rst_n = 1;
        step();
    endtask

    task automatic test_independent;
        set_idle();
        out_ready = 1;
        drive_instr(5'd1, 64'd5, 5'd2, 64'd7, 0, 64'd0, ALU_ADD, 5'd5);
        #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL indep_pre: got rdy=%b vld=%b expected 1/0", in_ready, out_valid); end
        step();
        in_valid = 0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL indep_valid: got %b expected 1", out_valid); end
        n_checks++; if (dataA !== 64'd5 || dataB !== 64'd7) begin n_fail++; $display("FAIL indep_data: got %h/%h expected 5/7", dataA, dataB); end
        n_checks++; if (ALUControl !== 4'b0000 || rd_out !== 5'd5 || reg_write_out !== 1'b1) begin n_fail++; $display("FAIL indep_ctrl: got %b/%0d/%b expected 0000/5/1", ALUControl, rd_out, reg_write_out); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL indep_consumed: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        set_idle();
        out_ready = 1;
        drive_instr(5'd8, 64'h10, 5'd9, 64'h20, 0, 64'd0, ALU_ADD, 5'd10);
        step();
        drive_instr(5'd8, 64'h11, 5'd9, 64'h21, 0, 64'd0, ALU_SUB, 5'd11);
        #1;
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || dataA !== 64'h10) begin n_fail++; $display("FAIL b2b_0: got vld=%b rdy=%b A=%h expected 1/1/10", out_valid, in_ready, dataA); end
        step();
        drive_instr(5'd8, 64'h12, 5'd9, 64'h22, 0, 64'd0, ALU_XOR, 5'd12);
        #1;
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || dataA !== 64'h11 || dataB !== 64'h21 || ALUControl !== ALU_SUB) begin n_fail++; $display("FAIL b2b_1: got vld=%b rdy=%b A=%h B=%h op=%b expected 1/1/11/21/1000", out_valid, in_ready, dataA, dataB, ALUControl); end
        step();
        in_valid = 0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || dataA !== 64'h12 || ALUControl !== ALU_XOR || rd_out !== 5'd12) begin n_fail++; $display("FAIL b2b_2: got vld=%b A=%h op=%b rd=%0d expected 1/12/0100/12", out_valid, dataA, ALUControl, rd_out); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_forward;
        set_idle();
        out_ready = 1;
        drive_instr(5'd3, 64'h11, 5'd2, 64'd7, 0, 64'd0, ALU_SUB, 5'd6);
        step();
        in_valid = 0;
        exm_reg_write = 1; exm_rd = 5'd3; exm_data = 64'h2A;
        #1;
`ifdef ALU_OPERAND_FORWARDING_EN
        n_checks++; if (out_valid !== 1'b1 || dataA !== 64'h2A || dataB !== 64'd7) begin n_fail++; $display("FAIL fwd_exm: got vld=%b A=%h B=%h expected 1/2a/7", out_valid, dataA, dataB); end
        step();
        exm_reg_write = 0;
`else
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_exm_stall: got %b expected 0", out_valid); end
        exp_stall++;
        step();
        exm_reg_write = 0;
        wb_reg_write = 1; wb_rd = 5'd3; wb_data = 64'h2A;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_wb_stall: got %b expected 0", out_valid); end
        exp_stall++;
        step();
        wb_reg_write = 0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || dataA !== 64'h2A) begin n_fail++; $display("FAIL fwd_snooped: got vld=%b A=%h expected 1/2a", out_valid, dataA); end
        step();
`endif
        n_checks++; if (stall_count !== exp_stall) begin n_fail++; $display("FAIL fwd_stall_count: got %0d expected %0d", stall_count, exp_stall); end
    endtask

    task automatic test_load_use;
        logic [31:0] base;
        base = exp_stall;
        set_idle();
        out_ready = 1;
        // rs2 field also names x4 but B is an immediate, so it must not track x4
        drive_instr(5'd4, 64'h10, 5'd4, 64'h0, 1, 64'd3, ALU_ADD, 5'd7);
        step();
        in_valid = 0;
        exm_reg_write = 1; exm_is_load = 1; exm_rd = 5'd4; exm_data = 64'hDEAD;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL load_bubble: got %b expected 0", out_valid); end
        exp_stall++;
        step();
        exm_reg_write = 0; exm_is_load = 0;
        wb_reg_write = 1; wb_rd = 5'd4; wb_data = 64'h99;
        #1;
`ifdef ALU_OPERAND_FORWARDING_EN
        n_checks++; if (out_valid !== 1'b1 || dataA !== 64'h99 || dataB !== 64'd3) begin n_fail++; $display("FAIL load_wb_bypass: got vld=%b A=%h B=%h expected 1/99/3", out_valid, dataA, dataB); end
        n_checks++; if (stall_count !== base + 32'd1) begin n_fail++; $display("FAIL load_stall_count: got %0d expected %0d", stall_count, base + 32'd1); end
        step();
        wb_reg_write = 0;
`else
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL load_wb_stall: got %b expected 0", out_valid); end
        exp_stall++;
        step();
        wb_reg_write = 0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || dataA !== 64'h99 || dataB !== 64'd3) begin n_fail++; $display("FAIL load_snooped: got vld=%b A=%h B=%h expected 1/99/3", out_valid, dataA, dataB); end
        step();
`endif
        n_checks++; if (stall_count !== exp_stall) begin n_fail++; $display("FAIL load_stall_total: got %0d expected %0d", stall_count, exp_stall); end
    endtask

    task automatic test_capture_snoop;
        set_idle();
        out_ready = 0;
        drive_instr(5'd5, 64'h1, 5'd6, 64'h2, 0, 64'd0, ALU_OR, 5'd9);
        wb_reg_write = 1; wb_rd = 5'd5; wb_data = 64'h77;
        step();
        in_valid = 0; wb_reg_write = 0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || dataA !== 64'h77 || dataB !== 64'h2) begin n_fail++; $display("FAIL capture_fix: got vld=%b A=%h B=%h expected 1/77/2", out_valid, dataA, dataB); end
        wb_reg_write = 1; wb_rd = 5'd6; wb_data = 64'h88;
        #1;
`ifdef ALU_OPERAND_FORWARDING_EN
        n_checks++; if (out_valid !== 1'b1 || dataB !== 64'h88) begin n_fail++; $display("FAIL snoop_bypass: got vld=%b B=%h expected 1/88", out_valid, dataB); end
`else
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL snoop_stall: got %b expected 0", out_valid); end
        exp_stall++;
`endif
        step();
        wb_reg_write = 0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || dataB !== 64'h88 || dataA !== 64'h77) begin n_fail++; $display("FAIL snoop_held: got vld=%b A=%h B=%h expected 1/77/88", out_valid, dataA, dataB); end
        out_ready = 1;
        step();
    endtask

    task automatic test_backpressure;
        set_idle();
        out_ready = 1;
        drive_instr(5'd1, 64'h100, 5'd2, 64'h200, 0, 64'd0, ALU_AND, 5'd6);
        step();
        out_ready = 0;
        drive_instr(5'd1, 64'h300, 5'd2, 64'h400, 0, 64'd0, ALU_OR, 5'd7);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || dataA !== 64'h100 || dataB !== 64'h200 || ALUControl !== ALU_AND || rd_out !== 5'd6) begin
                n_fail++; $display("FAIL bp_hold%0d: got rdy=%b vld=%b A=%h B=%h op=%b rd=%0d expected 0/1/100/200/0111/6", i, in_ready, out_valid, dataA, dataB, ALUControl, rd_out);
            end
            step();
        end
        out_ready = 1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || dataA !== 64'h300 || dataB !== 64'h400 || ALUControl !== ALU_OR || rd_out !== 5'd7) begin n_fail++; $display("FAIL bp_next: got vld=%b A=%h B=%h op=%b rd=%0d expected 1/300/400/0110/7", out_valid, dataA, dataB, ALUControl, rd_out); end
        step();
    endtask

    task automatic test_flush;
        set_idle();
        out_ready = 1;
        // Empty stage: incoming instruction accepted but flushed
        drive_instr(5'd1, 64'h5, 5'd2, 64'h6, 0, 64'd0, ALU_SLL, 5'd3);
        flush = 1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        step();
        flush = 0; in_valid = 0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_capture: got %b expected 0", out_valid); end
        // Held instruction killed while stalled downstream
        out_ready = 0;
        drive_instr(5'd1, 64'h8, 5'd2, 64'h9, 0, 64'd0, ALU_SRA, 5'd4);
        step();
        in_valid = 0;
        flush = 1;
        step();
        flush = 0; out_ready = 1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_held: got vld=%b rdy=%b expected 0/1", out_valid, in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stays_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_x0;
        set_idle();
        out_ready = 0;
        drive_instr(5'd0, 64'h0, 5'd2, 64'h9, 0, 64'd0, ALU_SLT, 5'd1);
        wb_reg_write = 1; wb_rd = 5'd0; wb_data = 64'h66;
        step();
        in_valid = 0;
        exm_reg_write = 1; exm_is_load = 1; exm_rd = 5'd0; exm_data = 64'h55;
        #1;
        n_checks++; if (out_valid !== 1'b1 || dataA !== 64'h0 || dataB !== 64'h9) begin n_fail++; $display("FAIL x0_bypass: got vld=%b A=%h B=%h expected 1/0/9", out_valid, dataA, dataB); end
        step();
        n_checks++; if (dataA !== 64'h0 || stall_count !== exp_stall) begin n_fail++; $display("FAIL x0_snoop: got A=%h stalls=%0d expected 0/%0d", dataA, stall_count, exp_stall); end
        exm_reg_write = 0; exm_is_load = 0; wb_reg_write = 0; out_ready = 1;
        step();
    endtask

    task automatic test_reset_mid;
        set_idle();
        out_ready = 0;
        drive_instr(5'd1, 64'hAB, 5'd2, 64'hCD, 0, 64'd0, ALU_SLTU, 5'd2);
        step();
        in_valid = 0;
        exm_reg_write = 1; exm_is_load = 1; exm_rd = 5'd1;
        step();
        rst_n = 0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || dataA !== 64'h0 || ALUControl !== 4'b0000 || stall_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid: got vld=%b A=%h op=%b stalls=%0d expected 0/0/0000/0", out_valid, dataA, ALUControl, stall_count);
        end
        exp_stall = 32'd0;
        set_idle();
        step();
        rst_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_independent();
        test_back_to_back();
        test_forward();
        test_load_use();
        test_capture_snoop();
        test_backpressure();
        test_flush();
        test_x0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_operand_stage
`default_nettype wire
